// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, synchronizes the
// columns, debounces press and release, and strobes out a hex key code.
module keypad_scanner #(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST   = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] PRESS_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] RELEASE_LAST = DW'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    col_q, col_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [3:0]    rows_q, rows_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic [3:0]    cs;
   logic [2:0]    low_hit;
   logic          col_match;

   // {valid, column}: valid only when exactly one column is pulled low
   function automatic logic [2:0] one_low(input logic [3:0] c);
      case (c)
         4'b1110: one_low = 3'b100;
         4'b1101: one_low = 3'b101;
         4'b1011: one_low = 3'b110;
         4'b0111: one_low = 3'b111;
         default: one_low = 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
      endcase
   endfunction

   assign cs        = sync2_q;
   assign low_hit   = one_low(cs);
   assign col_match = (cs == ~(4'b0001 << col_q));

   always_comb begin
      state_d     = state_q;
      sync1_d     = cols;
      sync2_d     = sync1_q;
      idx_d       = idx_q;
      col_d       = col_q;
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      case (state_q)
         SCAN: begin
            if (timer_q == TIMER_LAST) begin
               if (low_hit[2]) begin
                  state_d = DEBOUNCE;
                  col_d   = low_hit[1:0];
                  cnt_d   = '0;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  timer_d = '0;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DEBOUNCE: begin
            if (!col_match) begin
               state_d = SCAN;
               idx_d   = idx_q + 2'd1;
               timer_d = '0;
            end else if (cnt_q == PRESS_LAST) begin
               state_d     = HELD;
               key_d       = key_map(idx_q, col_q);
               key_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         HELD: begin
            if (cs[col_q]) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end
         RELEASE: begin
            // the HELD cycle that first saw the column high counts as sample one
            if (!cs[col_q]) begin
               state_d = HELD;
            end else if (cnt_q == RELEASE_LAST) begin
               state_d = SCAN;
               idx_d   = idx_q + 2'd1;
               timer_d = '0;
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
         default: state_d = SCAN;
      endcase
      key_held_d = (state_d == HELD) || (state_d == RELEASE);
      rows_d     = ~(4'b0001 << idx_d);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= SCAN;
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         idx_q       <= 2'd0;
         col_q       <= 2'd0;
         timer_q     <= '0;
         cnt_q       <= '0;
         rows_q      <= 4'b1110;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         idx_q       <= idx_d;
         col_q       <= col_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         rows_q      <= rows_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign rows      = rows_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives the columns from
// the row strobe, and a scoreboard of expected key codes is matched against each key_valid.
module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] cols;
   logic [3:0] rows;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   logic [3:0][3:0] pressed;

   typedef struct {
      logic [3:0] key;
      logic [3:0] rows;
   } expT;

   expT        sb[$];
   expT        cur;
   logic [3:0] heldRows;
   int         testsRun;
   int         failCount;

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cols(cols),
      .rows(rows),
      .key(key),
      .key_valid(key_valid),
      .key_held(key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key shorts its column to its row when that row is driven low
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         cols[c] = 1'b1;
         for (int r = 0; r < 4; r++) begin
            if (pressed[r][c] && !rows[r]) cols[c] = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int r, input int c, input logic down);
      pressed[r][c] = down;
   endtask

   task automatic applyReset(input string tag);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " rows"}, {28'd0, rows}, 32'hE);
      checkOutput({tag, " key"}, {28'd0, key}, 32'h0);
      checkOutput({tag, " key_valid"}, {31'd0, key_valid}, 32'd0);
      checkOutput({tag, " key_held"}, {31'd0, key_held}, 32'd0);
      reset = 1'b1;
   endtask

   task automatic waitHeld(input logic value, input int bound, input string tag);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (key_held === value) break;
      end
      checkOutput(tag, {31'd0, key_held}, {31'd0, value});
   endtask

   task automatic waitRowsEnter(input logic [3:0] target, input int bound);
      logic [3:0] prev;
      logic       seen;
      prev = rows;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (rows === target && prev !== target) begin
            seen = 1'b1;
            break;
         end
         prev = rows;
      end
      checkOutput("rows enter target", {31'd0, seen}, 32'd1);
   endtask

   // Scoreboard consumer: every strobe must match the oldest pending expectation
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious key_valid", {31'd0, key_valid}, 32'd0);
         end else begin
            cur      = sb.pop_front();
            heldRows = cur.rows;
            checkOutput("strobe key", {28'd0, key}, {28'd0, cur.key});
            checkOutput("strobe rows", {28'd0, rows}, {28'd0, cur.rows});
         end
      end else if (key_held === 1'b1) begin
         checkOutput("rows frozen while held", {28'd0, rows}, {28'd0, heldRows});
      end
   end

   initial begin
      int         lat;
      logic [3:0] expRows;
      testsRun  = 0;
      failCount = 0;
      heldRows  = 4'hF;
      pressed   = '0;
      reset     = 1'b0;

      // Idle scan after reset
      applyReset("reset");
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         expRows = ~(4'b0001 << ((k / 4) % 4));
         checkOutput("idle rows", {28'd0, rows}, {28'd0, expRows});
      end
      checkOutput("idle key", {28'd0, key}, 32'h0);

      // Key '6' held then released
      sb.push_back('{key: 4'h6, rows: 4'b1101});
      applyStimulus(1, 2, 1'b1);
      waitHeld(1'b1, 40, "6 held");
      repeat (30) @(negedge clk);
      applyStimulus(1, 2, 1'b0);
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) begin
            lat = i;
            break;
         end
      end
      checkOutput("6 release latency", 32'(lat), 32'd10);
      checkOutput("rows after 6", {28'd0, rows}, 32'hB);
      checkOutput("key after 6", {28'd0, key}, 32'h6);

      // Short '9' press enters debounce and is rejected
      waitRowsEnter(4'b1011, 40);
      applyStimulus(2, 2, 1'b1);
      repeat (3) @(negedge clk);
      applyStimulus(2, 2, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("9 debounce freezes rows", {28'd0, rows}, 32'hB);
      @(negedge clk);
      checkOutput("9 scan resumes", {28'd0, rows}, 32'h7);
      repeat (20) @(negedge clk);
      checkOutput("key kept after 9", {28'd0, key}, 32'h6);
      checkOutput("held after 9", {31'd0, key_held}, 32'd0);

      // 'D' with release bounce
      sb.push_back('{key: 4'hD, rows: 4'b0111});
      applyStimulus(3, 3, 1'b1);
      waitHeld(1'b1, 40, "D held");
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3, 3, (i % 2) == 1);
         repeat (2) @(negedge clk);
         if (i == 3) checkOutput("D held during bounce", {31'd0, key_held}, 32'd1);
      end
      waitHeld(1'b0, 30, "D released");
      checkOutput("rows after D", {28'd0, rows}, 32'hE);
      checkOutput("key after D", {28'd0, key}, 32'hD);

      // '1' and '2' together are ignored
      applyStimulus(0, 0, 1'b1);
      applyStimulus(0, 1, 1'b1);
      repeat (40) @(negedge clk);
      checkOutput("1+2 not held", {31'd0, key_held}, 32'd0);
      checkOutput("1+2 key kept", {28'd0, key}, 32'hD);
      applyStimulus(0, 0, 1'b0);
      applyStimulus(0, 1, 1'b0);

      // 'A' held, '5' added; '5' only registers after 'A' is released
      sb.push_back('{key: 4'hA, rows: 4'b1110});
      applyStimulus(0, 3, 1'b1);
      waitHeld(1'b1, 40, "A held");
      applyStimulus(1, 1, 1'b1);
      repeat (30) @(negedge clk);
      checkOutput("A kept with 5", {28'd0, key}, 32'hA);
      checkOutput("A still held", {31'd0, key_held}, 32'd1);
      sb.push_back('{key: 4'h5, rows: 4'b1101});
      applyStimulus(0, 3, 1'b0);
      waitHeld(1'b0, 30, "A released");
      waitHeld(1'b1, 40, "5 held");
      checkOutput("key 5", {28'd0, key}, 32'h5);
      applyStimulus(1, 1, 1'b0);
      waitHeld(1'b0, 30, "5 released");

      // Reset during DEBOUNCE and during HELD with '8' still down
      waitRowsEnter(4'b1011, 40);
      applyStimulus(2, 1, 1'b1);
      repeat (5) @(negedge clk);
      applyReset("reset in debounce");
      sb.push_back('{key: 4'h8, rows: 4'b1011});
      waitHeld(1'b1, 60, "8 held after reset");
      repeat (3) @(negedge clk);
      applyReset("reset in held");
      sb.push_back('{key: 4'h8, rows: 4'b1011});
      waitHeld(1'b1, 60, "8 re-held");
      applyStimulus(2, 1, 1'b0);
      waitHeld(1'b0, 30, "8 released");
      repeat (10) @(negedge clk);
      checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
